// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Stall/forward controller that sits beside the decode (D) stage of the
// pipelined MIPS core. It keeps one registered record {addr, tnew} per
// post-decode stage (1 = E, 2 = M, 3 = W). From those records it derives,
// for each D-stage source register, whether D must stall and which stage
// result (if any) to forward. It also owns the HI/LO multiply/divide busy
// counter, so mult/div/mfhi/mflo/mthi/mtlo hazards are resolved here too.
//
// Stall contract: stall is combinational from the current records, the md
// counter and the D-stage inputs. While stall is high the core holds PC and
// F/D and this block inserts a bubble into record 1. flush alone has the same
// effect on record 1 (the D instruction is killed), but does not raise stall.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   d_rs, d_rt                 D-stage source addresses
//   d_rs_use, d_rt_use         source is actually read
//   d_tuse_rs, d_tuse_rt       cycles after D until the source value is needed
//   d_dst, d_tnew              D-stage destination (0 = none) and its tnew
//   d_md_access                D instruction touches the HI/LO unit
//   e_md_start, e_md_is_div    mult/div issuing in E this cycle, and its kind
//   flush                      kill the D instruction
//   stall                      hold PC and F/D, bubble into E
//   fwd_sel_rs, fwd_sel_rt     0 = register file, k = stage k result
//   md_busy                    HI/LO unit busy
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter  int STAGES     = 3,
  parameter  int AW         = 5,
  parameter  int TW         = 2,
  parameter  int MUL_CYCLES = 5,
  parameter  int DIV_CYCLES = 10,
  localparam int SW         = $clog2(STAGES + 1),
  localparam int MAXC       = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES,
  localparam int CW         = $clog2(MAXC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_use,
  input  logic          d_rt_use,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_access,
  input  logic          e_md_start,
  input  logic          e_md_is_div,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_sel_rs,
  output logic [SW-1:0] fwd_sel_rt,
  output logic          md_busy
);

  // Per-stage in-flight write records; index 1 is the youngest (E).
  logic [AW-1:0] addr_q [1:STAGES];
  logic [TW-1:0] tnew_q [1:STAGES];
  logic [AW-1:0] addr_d [1:STAGES];
  logic [TW-1:0] tnew_d [1:STAGES];

  logic [CW-1:0] cnt_q, cnt_d;

  // Youngest-match lookup results per source.
  logic          rs_hit, rt_hit;
  logic [SW-1:0] rs_k, rt_k;
  logic [TW-1:0] rs_tnew, rt_tnew;

  logic data_stall_rs, data_stall_rt, md_stall;

  // Scan from the oldest stage towards the youngest so that the last hit
  // written is the smallest k: older writers of the same register are
  // shadowed by younger ones. Bubbles carry addr 0, and source 0 is
  // excluded, so address 0 can never match.
  always_comb begin
    rs_hit  = 1'b0;
    rs_k    = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_k    = '0;
    rt_tnew = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (d_rs_use && (d_rs != '0) && (addr_q[k] == d_rs)) begin
        rs_hit  = 1'b1;
        rs_k    = SW'(k);
        rs_tnew = tnew_q[k];
      end
      if (d_rt_use && (d_rt != '0) && (addr_q[k] == d_rt)) begin
        rt_hit  = 1'b1;
        rt_k    = SW'(k);
        rt_tnew = tnew_q[k];
      end
    end
  end

  // A matched producer that is not ready yet but will be ready before the
  // consumer needs it neither stalls nor forwards now; a later stage
  // resolves it.
  always_comb begin
    data_stall_rs = rs_hit && (rs_tnew > d_tuse_rs);
    data_stall_rt = rt_hit && (rt_tnew > d_tuse_rt);
    fwd_sel_rs    = (rs_hit && (rs_tnew == '0)) ? rs_k : '0;
    fwd_sel_rt    = (rt_hit && (rt_tnew == '0)) ? rt_k : '0;
  end

  // A start in E this very cycle already occupies the unit even though the
  // counter only loads on the next edge.
  always_comb begin
    md_busy  = (cnt_q != '0);
    md_stall = d_md_access && (md_busy || e_md_start);
    stall    = data_stall_rs || data_stall_rt || md_stall;
  end

  // Record pipeline: stall or flush turns the E entry into a bubble;
  // older stages age their tnew with a saturating decrement.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      addr_d[k] = '0;
      tnew_d[k] = '0;
    end
    if (!(stall || flush)) begin
      addr_d[1] = d_dst;
      tnew_d[1] = d_tnew;
    end
    for (int k = 2; k <= STAGES; k++) begin
      addr_d[k] = addr_q[k-1];
      tnew_d[k] = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - 1'b1) : '0;
    end
  end

  // MD counter: a start is only accepted when idle; a start while busy is
  // dropped rather than reloading the count.
  always_comb begin
    cnt_d = cnt_q;
    if (e_md_start && (cnt_q == '0)) begin
      cnt_d = e_md_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        addr_q[k] <= addr_d[k];
        tnew_q[k] <= tnew_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Bench for hazard_scoreboard: a table of per-cycle {inputs, expected
// outputs} records for the directed scenarios, a hand-written async reset
// sequence during a pending stall, then randomized traffic checked against
// an age-based model of in-flight writes and an absolute-cycle model of the
// HI/LO busy window.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int STAGES     = 3;
  localparam int AW         = 5;
  localparam int TW         = 2;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
  localparam int SW         = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] d_rs, d_rt, d_dst;
  logic          d_rs_use, d_rt_use;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          d_md_access, e_md_start, e_md_is_div, flush;
  logic          stall, md_busy;
  logic [SW-1:0] fwd_sel_rs, fwd_sel_rt;

  hazard_scoreboard #(
    .STAGES(STAGES), .AW(AW), .TW(TW),
    .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_access(d_md_access), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .flush(flush),
    .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
    .md_busy(md_busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- vector table ----------------
  typedef struct {
    int rs, rs_use, tuse_rs, rt, rt_use, tuse_rt, dst, tnew;
    int mda, mds, mdd, fl;
    int es, ers, ert, eb;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int rs, rs_use, tuse_rs, rt, rt_use, tuse_rt, dst, tnew,
                     input int mda, mds, mdd, fl, es, ers, ert, eb);
    vec_t v;
    v = '{rs, rs_use, tuse_rs, rt, rt_use, tuse_rt, dst, tnew, mda, mds, mdd, fl, es, ers, ert, eb};
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input int eb);
    for (int i = 0; i < n; i++) add(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,eb);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    d_rs = '0; d_rt = '0; d_rs_use = 1'b0; d_rt_use = 1'b0;
    d_tuse_rs = '0; d_tuse_rt = '0; d_dst = '0; d_tnew = '0;
    d_md_access = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    d_rs = AW'(v.rs); d_rs_use = v.rs_use[0]; d_tuse_rs = TW'(v.tuse_rs);
    d_rt = AW'(v.rt); d_rt_use = v.rt_use[0]; d_tuse_rt = TW'(v.tuse_rt);
    d_dst = AW'(v.dst); d_tnew = TW'(v.tnew);
    d_md_access = v.mda[0]; e_md_start = v.mds[0]; e_md_is_div = v.mdd[0];
    flush = v.fl[0];
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int es, input int ers, input int ert, input int eb);
    check({tag, ".stall"},      32'(stall),      32'(es));
    check({tag, ".fwd_sel_rs"}, 32'(fwd_sel_rs), 32'(ers));
    check({tag, ".fwd_sel_rt"}, 32'(fwd_sel_rt), 32'(ert));
    check({tag, ".md_busy"},    32'(md_busy),    32'(eb));
  endtask

  // ---------------- reference model ----------------
  // Each accepted writer is remembered with the cycle it first occupies E;
  // its stage and remaining latency follow from its age.
  typedef struct { int dst; int tnew; int enter; } wr_t;
  wr_t infl[$];
  int  busy_end;

  function automatic void lookup(input int src, input bit use_s, input int tuse, input int t,
                                 output bit stl, output int sel);
    int best;
    int rem;
    best = STAGES + 1;
    rem  = 0;
    stl  = 1'b0;
    sel  = 0;
    if (src == 0 || !use_s) return;
    foreach (infl[i]) begin
      int stage;
      stage = t - infl[i].enter + 1;
      if (stage >= 1 && stage <= STAGES && infl[i].dst == src && stage < best) begin
        best = stage;
        rem  = infl[i].tnew - (stage - 1);
        if (rem < 0) rem = 0;
      end
    end
    if (best <= STAGES) begin
      stl = (rem > tuse);
      sel = (rem == 0) ? best : 0;
    end
  endfunction

  // ---------------- test ----------------
  initial begin
    bit s_rs, s_rt, busy_now, exp_md, exp_stall;
    int f_rs, f_rt;

    reset = 1'b1;
    drive_idle();
    #2;
    check_outs("reset_async", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_outs("reset_held", 0, 0, 0, 0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;

    // Load-use: lw $8 (tnew 2), addu reads $8 at tuse 0.
    add(0,0,0, 0,0,0, 8,2, 0,0,0,0, 0,0,0,0);
    add(8,1,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    add(8,1,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    add(8,1,0, 0,0,0, 0,0, 0,0,0,0, 0,3,0,0);
    idle(3, 0);
    // ALU result (tnew 1) read at tuse 0.
    add(0,0,0, 0,0,0, 9,1, 0,0,0,0, 0,0,0,0);
    add(9,1,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    add(9,1,0, 0,0,0, 0,0, 0,0,0,0, 0,2,0,0);
    idle(3, 0);
    // addu $9 then sw reads $9 as rt with tuse 1: no stall, forward later.
    add(0,0,0, 0,0,0, 9,1, 0,0,0,0, 0,0,0,0);
    add(0,0,0, 9,1,1, 0,0, 0,0,0,0, 0,0,0,0);
    add(0,0,0, 9,1,1, 0,0, 0,0,0,0, 0,0,2,0);
    idle(3, 0);
    // Two writers to $4: the younger (tnew 1) governs.
    add(0,0,0, 0,0,0, 4,0, 0,0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0, 4,1, 0,0,0,0, 0,0,0,0);
    add(4,1,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    add(4,1,0, 0,0,0, 0,0, 0,0,0,0, 0,2,0,0);
    idle(3, 0);
    // rs and rt forwarded from different stages at once.
    add(0,0,0, 0,0,0, 13,0, 0,0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0, 14,0, 0,0,0,0, 0,0,0,0);
    add(13,1,0, 14,1,0, 0,0, 0,0,0,0, 0,2,1,0);
    idle(3, 0);
    // mult with mflo in D; a second start while busy (as div) is dropped.
    add(0,0,0, 0,0,0, 0,0, 1,1,0,0, 1,0,0,0);
    add(0,0,0, 0,0,0, 0,0, 1,0,0,0, 1,0,0,1);
    add(0,0,0, 0,0,0, 0,0, 1,1,1,0, 1,0,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0, 0,0, 1,0,0,0, 1,0,0,1);
    add(0,0,0, 0,0,0, 0,0, 1,0,0,0, 0,0,0,0);
    // div with no HI/LO access in D: busy but no stall.
    add(0,0,0, 0,0,0, 0,0, 0,1,1,0, 0,0,0,0);
    idle(DIV_CYCLES, 1);
    idle(1, 0);
    // $0 never matches; unused sources never match; tuse equal to tnew.
    add(0,0,0, 0,0,0, 0,2, 0,0,0,0, 0,0,0,0);
    add(0,1,0, 0,1,0, 0,0, 0,0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0, 7,2, 0,0,0,0, 0,0,0,0);
    add(7,0,0, 7,1,2, 0,0, 0,0,0,0, 0,0,0,0);
    add(7,0,0, 7,1,2, 0,0, 0,0,0,0, 0,0,0,0);
    add(7,0,0, 7,1,2, 0,0, 0,0,0,0, 0,0,3,0);
    idle(3, 0);
    // flush during a pending stall: killed writer $11 must not be recorded.
    add(0,0,0, 0,0,0, 6,2, 0,0,0,0, 0,0,0,0);
    add(6,1,0, 0,0,0, 11,0, 0,0,0,1, 1,0,0,0);
    add(11,1,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0);
    idle(3, 0);
    // flush alone: killed writer $12 must not be recorded.
    add(0,0,0, 0,0,0, 12,0, 0,0,0,1, 0,0,0,0);
    add(12,1,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0);
    idle(3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("row%0d", i), vecs[i].es, vecs[i].ers, vecs[i].ert, vecs[i].eb);
      @(posedge clk); #1;
    end

    // Async reset while a load-use stall and a multiply are pending.
    drive_idle();
    d_dst = 5'd5; d_tnew = 2'd2; e_md_start = 1'b1;
    @(negedge clk);
    check_outs("rst_seq.issue", 0, 0, 0, 0);
    @(posedge clk); #1;
    drive_idle();
    d_rs = 5'd5; d_rs_use = 1'b1; d_md_access = 1'b1;
    @(negedge clk);
    check_outs("rst_seq.pending", 1, 0, 0, 1);
    #1 reset = 1'b1;
    #1;
    check_outs("rst_seq.cleared", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_outs("rst_seq.held", 0, 0, 0, 0);
    #2 reset = 1'b0;
    drive_idle();
    @(posedge clk); #1;

    // Randomized traffic against the model; state is clean after reset.
    infl.delete();
    busy_end = -1;
    for (int t = 0; t < 400; t++) begin
      d_rs        = AW'($urandom_range(0, 3));
      d_rt        = AW'($urandom_range(0, 3));
      d_rs_use    = 1'($urandom_range(0, 1));
      d_rt_use    = 1'($urandom_range(0, 1));
      d_tuse_rs   = TW'($urandom_range(0, 2));
      d_tuse_rt   = TW'($urandom_range(0, 2));
      d_dst       = AW'($urandom_range(0, 3));
      d_tnew      = TW'($urandom_range(0, 3));
      d_md_access = ($urandom_range(0, 3) == 0);
      e_md_start  = ($urandom_range(0, 7) == 0);
      e_md_is_div = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 7) == 0);

      lookup(int'(d_rs), d_rs_use, int'(d_tuse_rs), t, s_rs, f_rs);
      lookup(int'(d_rt), d_rt_use, int'(d_tuse_rt), t, s_rt, f_rt);
      busy_now  = (t <= busy_end);
      exp_md    = d_md_access && (busy_now || e_md_start);
      exp_stall = s_rs || s_rt || exp_md;

      @(negedge clk);
      check_outs($sformatf("rand%0d", t), int'(exp_stall), f_rs, f_rt, int'(busy_now));

      if (e_md_start && !busy_now)
        busy_end = t + (e_md_is_div ? DIV_CYCLES : MUL_CYCLES);
      if (!exp_stall && !flush && d_dst != '0)
        infl.push_back('{int'(d_dst), int'(d_tnew), t + 1});
      while (infl.size() > 0 && (t + 1 - infl[0].enter + 1) > STAGES)
        void'(infl.pop_front());

      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
